// File: rtl/soc_gpio_pad_port.sv
// soc_gpio_pad_port: pad-side GPIO glue with synchronizer, vector debouncer, registered outputs and sticky irq.
module soc_gpio_pad_port #(
  parameter int DEBOUNCE_LEN = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pad_in,
  output logic [31:0] din,
  input  logic [31:0] dout,
  input  logic        irq,
  output logic [31:0] pad_out,
  output logic        din_changed,
  output logic        irq_out,
  input  logic        irq_ack,
  output logic        irq_missed
);
  localparam logic [7:0] LEN  = 8'(DEBOUNCE_LEN);
  localparam logic [7:0] LAST = 8'(DEBOUNCE_LEN - 1);
  logic [31:0] r_s1, r_s2, r_stable;
  logic [7:0]  r_cnt;
  logic        r_irq_q;
  logic        w_diff, w_load, w_edge;
  assign w_diff = r_s2 != r_stable;
  assign w_load = !w_diff && r_cnt == LAST;
  assign w_edge = irq & ~r_irq_q;
  // the candidate always tracks s2; only a mismatch restarts the shared count
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_s1        <= '0;
      r_s2        <= '0;
      r_stable    <= '0;
      r_cnt       <= LEN;
      din         <= '0;
      din_changed <= 1'b0;
      pad_out     <= '0;
      r_irq_q     <= 1'b0;
      irq_out     <= 1'b0;
      irq_missed  <= 1'b0;
    end else begin
      r_s1        <= pad_in;
      r_s2        <= r_s1;
      r_stable    <= r_s2;
      r_cnt       <= w_diff ? 8'd0 : (r_cnt < LEN ? r_cnt + 8'd1 : r_cnt);
      din         <= w_load ? r_stable : din;
      din_changed <= w_load && r_stable != din;
      pad_out     <= dout;
      r_irq_q     <= irq;
      irq_out     <= w_edge | (irq_out & ~irq_ack);
      irq_missed  <= (w_edge & irq_out & ~irq_ack) | (irq_missed & ~irq_ack);
    end
endmodule

// File: tb/tb_soc_gpio_pad_port.sv
// tb_soc_gpio_pad_port: randomized scoreboard bench for two debounce lengths against a history-based model.
module tb_soc_gpio_pad_port;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [31:0] pad_in = '0, dout = '0;
  logic irq = 1'b0, irq_ack = 1'b0;
  logic [31:0] din4, pad_out4, din1, pad_out1;
  logic ch4, io4, im4, ch1, io1, im1;
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  soc_gpio_pad_port #(.DEBOUNCE_LEN(4)) u4 (.clk(clk), .rst_n(rst_n), .pad_in(pad_in), .din(din4), .dout(dout),
    .irq(irq), .pad_out(pad_out4), .din_changed(ch4), .irq_out(io4), .irq_ack(irq_ack), .irq_missed(im4));
  soc_gpio_pad_port #(.DEBOUNCE_LEN(1)) u1 (.clk(clk), .rst_n(rst_n), .pad_in(pad_in), .din(din1), .dout(dout),
    .irq(irq), .pad_out(pad_out1), .din_changed(ch1), .irq_out(io1), .irq_ack(irq_ack), .irq_missed(im1));

  typedef struct {
    logic [31:0] din [2];
    logic        ch  [2];
    logic [31:0] pad_out;
    logic        irq_out, missed;
  } exp_t;
  exp_t q [$];

  int          len [2] = '{4, 1};
  logic [31:0] padh [$];
  logic [31:0] sh [2][6];
  logic [31:0] dm [2];
  logic        m_prev, m_out, m_missed;

  // a load happens when the synchronized level changed exactly LEN edges ago and has held since
  task automatic model_reset();
    padh = {32'h0, 32'h0};
    for (int k = 0; k < 2; k++) begin
      dm[k] = '0;
      for (int i = 0; i < 6; i++) sh[k][i] = '0;
    end
    m_prev = 1'b0; m_out = 1'b0; m_missed = 1'b0;
  endtask

  task automatic step();
    exp_t e;
    logic [31:0] s;
    logic ld, edg;
    int d;
    for (int k = 0; k < 2; k++) begin e.din[k] = '0; e.ch[k] = 1'b0; end
    e.pad_out = '0; e.irq_out = 1'b0; e.missed = 1'b0;
    if (!rst_n) model_reset();
    else begin
      s = padh[0];
      padh.push_back(pad_in);
      void'(padh.pop_front());
      for (int k = 0; k < 2; k++) begin
        d = len[k] + 2;
        for (int i = 0; i < d - 1; i++) sh[k][i] = sh[k][i+1];
        sh[k][d-1] = s;
        ld = sh[k][0] != sh[k][1];
        for (int i = 2; i < d; i++) ld = ld && (sh[k][i] == sh[k][1]);
        e.ch[k] = ld && (sh[k][1] != dm[k]);
        if (ld) dm[k] = sh[k][1];
        e.din[k] = dm[k];
      end
      edg = irq && !m_prev;
      m_prev = irq;
      m_missed = (edg && m_out && !irq_ack) || (m_missed && !irq_ack);
      m_out = edg || (m_out && !irq_ack);
      e.pad_out = dout; e.irq_out = m_out; e.missed = m_missed;
    end
    q.push_back(e);
  endtask

  task automatic drv(input logic [31:0] p, input logic [31:0] d, input logic i, input logic a, input logic r);
    @(negedge clk);
    pad_in = p; dout = d; irq = i; irq_ack = a; rst_n = r;
    step();
  endtask

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s at %0t: got=%h want=%h", n, $time, act, req);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("din_len4", din4, e.din[0]);
        chk("din_changed_len4", 32'(ch4), 32'(e.ch[0]));
        chk("din_len1", din1, e.din[1]);
        chk("din_changed_len1", 32'(ch1), 32'(e.ch[1]));
        chk("pad_out_len4", pad_out4, e.pad_out);
        chk("pad_out_len1", pad_out1, e.pad_out);
        chk("irq_out_len4", 32'(io4), 32'(e.irq_out));
        chk("irq_out_len1", 32'(io1), 32'(e.irq_out));
        chk("irq_missed_len4", 32'(im4), 32'(e.missed));
        chk("irq_missed_len1", 32'(im1), 32'(e.missed));
      end
    end
  end

  initial begin
    logic [31:0] p;
    int hold;
    model_reset();
    repeat (2) drv('0, '0, 1'b0, 1'b0, 1'b0);
    repeat (10) drv(32'h0000_00A5, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b1);
    repeat (2) drv('0, '0, 1'b0, 1'b0, 1'b0);
    repeat (3) drv(32'h1, 32'h1234_5678, 1'b0, 1'b0, 1'b1);
    repeat (10) drv(32'h0, 32'h1234_5678, 1'b0, 1'b0, 1'b1);
    repeat (10) drv(32'h0, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b1);
    repeat (2) drv(32'h0, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b1);
    drv('0, '0, 1'b1, 1'b0, 1'b1); drv('0, '0, 1'b0, 1'b0, 1'b1);
    drv('0, '0, 1'b1, 1'b0, 1'b1); drv('0, '0, 1'b0, 1'b0, 1'b1);
    drv('0, '0, 1'b0, 1'b1, 1'b1); drv('0, '0, 1'b0, 1'b0, 1'b1);
    drv('0, '0, 1'b1, 1'b0, 1'b1); drv('0, '0, 1'b0, 1'b0, 1'b1);
    drv('0, '0, 1'b1, 1'b1, 1'b1); drv('0, '0, 1'b0, 1'b0, 1'b1);
    repeat (2) drv('0, '0, 1'b0, 1'b0, 1'b0);
    repeat (5) drv(32'hFFFF_FFFF, '0, 1'b0, 1'b0, 1'b1);
    repeat (2) drv(32'hFFFF_FFFF, '0, 1'b0, 1'b0, 1'b0);
    repeat (10) drv(32'hFFFF_FFFF, '0, 1'b0, 1'b0, 1'b1);
    repeat (2) drv('0, '0, 1'b0, 1'b0, 1'b0);
    repeat (6) drv(32'h1, '0, 1'b0, 1'b0, 1'b1);
    p = 32'h1; hold = 0;
    repeat (2000) begin
      if (hold == 0) begin
        case ($urandom_range(0, 3))
          0: p = p ^ (32'h1 << $urandom_range(0, 31));
          1: p = $urandom;
          2: p = '0;
          default: p = p;
        endcase
        hold = $urandom_range(1, 7);
      end
      hold--;
      drv(p, $urandom, $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 199) != 0);
    end
    drv(p, '0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5 && q.size() > 0; i++) begin @(posedge clk); #2; end
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: pending=%0d want=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/soc_gpio_pad_port.md
SOC_GPIO_PAD_PORT -- requirements
Module: soc_gpio_pad_port

Interface
REQ-001 SHALL have parameter DEBOUNCE_LEN, default 4, giving the number of consecutive stable cycles required before a pad change is accepted; legal range 1..255.
REQ-002 SHALL use a single clock and an asynchronous, active-low reset, with ports clk then rst_n.
REQ-003 SHALL have port clk, input, 1 bit: system clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have port pad_in, input, 32 bits: asynchronous external pad levels.
REQ-006 SHALL have port din, output, 32 bits: debounced pad levels toward the GPIO peripheral (slave-side din of the SoC GPIO bus).
REQ-007 SHALL have port dout, input, 32 bits: output levels from the GPIO peripheral.
REQ-008 SHALL have port irq, input, 1 bit: synchronous interrupt level from the GPIO peripheral.
REQ-009 SHALL have port pad_out, output, 32 bits: registered copy of dout driven to pads.
REQ-010 SHALL have port din_changed, output, 1 bit: one-cycle pulse when din takes a new value.
REQ-011 SHALL have port irq_out, output, 1 bit: sticky pending interrupt to the core.
REQ-012 SHALL have port irq_ack, input, 1 bit: core acknowledge that clears the pending interrupt.
REQ-013 SHALL have port irq_missed, output, 1 bit: sticky flag set when an interrupt edge arrives while one is already pending.

Function
REQ-014 SHALL pass pad_in through a two-flop synchronizer (s1, then s2); no other logic SHALL read pad_in.
REQ-015 SHALL hold a candidate register stable_q and a saturating counter cnt (8 bits).
REQ-016 SHALL, when s2 != stable_q, load stable_q <= s2 and cnt <= 0.
REQ-017 SHALL, when s2 == stable_q and cnt == DEBOUNCE_LEN-1, load cnt <= DEBOUNCE_LEN and din <= stable_q.
REQ-018 SHALL, when s2 == stable_q and cnt < DEBOUNCE_LEN-1, increment cnt; at cnt == DEBOUNCE_LEN, cnt SHALL hold.
REQ-019 SHALL debounce with one shared counter for all 32 bits: a change on any bit restarts qualification for the whole vector.
REQ-020 SHALL give a total pad-to-din latency of 3+DEBOUNCE_LEN rising edges for a single clean transition.
REQ-021 SHALL pulse din_changed for exactly the cycle after din is loaded with a value different from its previous value; a reload with an equal value SHALL NOT pulse it.
REQ-022 SHALL update pad_out <= dout every cycle, giving 1-cycle latency.
REQ-023 SHALL register irq into irq_q and detect a rising edge as irq & ~irq_q.
REQ-024 SHALL set irq_out on a rising edge; irq_ack SHALL clear it; on a simultaneous edge and ack, set SHALL win.
REQ-025 SHALL set irq_missed on a rising edge while irq_out==1 and irq_ack==0; irq_ack SHALL clear irq_missed, except when it is set in the same cycle, in which case set SHALL win.
REQ-026 SHALL NOT generate a new edge from an irq held high continuously.

Reset
REQ-027 SHALL, on rst_n low, asynchronously clear s1, s2, stable_q, din, pad_out, irq_q, irq_out, irq_missed and din_changed to 0, and set cnt to DEBOUNCE_LEN.
REQ-028 SHALL, when reset is asserted mid-qualification, discard the pending candidate; after release, din SHALL follow REQ-020 from the first sampled value.
REQ-029 SHALL resume normal operation on the first rising clk edge after rst_n deasserts; no extra settling cycles.

Verification
REQ-030 SHALL cover: DEBOUNCE_LEN=4, pad_in 0 -> 0x0000_00A5 held -> din=0x0000_00A5 on edge 7, with din_changed high for one cycle on the following cycle.
REQ-031 SHALL cover: pad_in bit0 glitch high for 3 cycles then low, DEBOUNCE_LEN=4 -> din stays 0 and din_changed never pulses.
REQ-032 SHALL cover: dout=0xDEAD_BEEF -> pad_out=0xDEAD_BEEF after 1 edge; with irq held high for 10 cycles -> irq_out set once, irq_missed stays 0.
REQ-033 SHALL cover: two irq pulses with no ack -> irq_out=1, irq_missed=1; then irq_ack for 1 cycle -> both 0; irq edge coincident with ack -> irq_out=1.
REQ-034 SHALL cover: rst_n low at cnt=2 during qualification of 0xFFFF_FFFF -> all outputs 0 immediately; after release with pad held, din=0xFFFF_FFFF on edge 7.
REQ-035 SHALL cover: DEBOUNCE_LEN=1, pad_in 0 -> 0x1 -> din=0x1 on edge 4.
